// File: rtl/uart_tx_if.sv
// Byte write channel into the UART transmitter.
// The master offers data/valid; the transmitter answers with a registered ready.
interface uart_tx_if;
   logic [7:0] uart_wr_data;
   logic       uart_wr_valid;
   logic       uart_wr_ready;

   modport master (
      output uart_wr_data,
      output uart_wr_valid,
      input  uart_wr_ready
   );

   modport slave (
      input  uart_wr_data,
      input  uart_wr_valid,
      output uart_wr_ready
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one-byte holding register feeding a shift FSM, LSB first,
// frame formats 8N1/8E1/8O1/8N2, all outputs driven from flops.
module uart_tx #(
   parameter int CLK_FREQ  = 100000000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst,
   uart_tx_if.slave   wr,
   input  logic [1:0] uart_mode,
   output logic       uart_txd,
   output logic       tx_busy
);

   localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

   localparam logic [1:0] MODE_8N1 = 2'b00;
   localparam logic [1:0] MODE_8E1 = 2'b01;
   localparam logic [1:0] MODE_8O1 = 2'b10;
   localparam logic [1:0] MODE_8N2 = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       idx_q;
   logic             stop2_q;
   logic [7:0]       shift_q;
   logic [1:0]       mode_q;
   logic [7:0]       hold_q;
   logic             hold_full_q;
   logic             ready_q;
   logic             txd_q;
   logic             busy_q;

   logic             xfer;
   logic             bit_end;
   logic             two_stop;
   logic             has_parity;
   logic             frame_end;
   logic             load;
   logic             hold_full_d;
   logic             parity_bit;

   always_comb begin
      xfer        = wr.uart_wr_valid & ready_q;
      bit_end     = (cnt_q == CNT_LAST);
      two_stop    = (mode_q == MODE_8N2);
      has_parity  = (mode_q == MODE_8E1) | (mode_q == MODE_8O1);
      frame_end   = (state_q == S_STOP) & bit_end & (~two_stop | stop2_q);
      // The shifter takes the held byte either from idle or on the very last
      // stop cycle, so consecutive frames abut with no idle bit between them.
      load        = hold_full_q & ((state_q == S_IDLE) | frame_end);
      hold_full_d = (hold_full_q & ~load) | xfer;
      parity_bit  = (^shift_q) ^ (mode_q == MODE_8O1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         stop2_q     <= 1'b0;
         shift_q     <= '0;
         mode_q      <= MODE_8N1;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         ready_q     <= 1'b0;
         txd_q       <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         hold_full_q <= hold_full_d;
         ready_q     <= ~hold_full_d;
         if (xfer) hold_q <= wr.uart_wr_data;

         busy_q <= (state_q != S_IDLE) | hold_full_q;

         // Line level follows the state one cycle later so every level,
         // including the first start bit, lasts exactly BIT_CYCLES clocks.
         unique case (state_q)
            S_IDLE:   txd_q <= 1'b1;
            S_START:  txd_q <= 1'b0;
            S_DATA:   txd_q <= shift_q[idx_q];
            S_PARITY: txd_q <= parity_bit;
            S_STOP:   txd_q <= 1'b1;
            default:  txd_q <= 1'b1;
         endcase

         if (state_q == S_IDLE || bit_end) cnt_q <= '0;
         else                              cnt_q <= cnt_q + CNT_W'(1);

         unique case (state_q)
            S_IDLE: begin
               if (load) begin
                  state_q <= S_START;
                  shift_q <= hold_q;
                  mode_q  <= uart_mode;
               end
            end
            S_START: begin
               if (bit_end) begin
                  state_q <= S_DATA;
                  idx_q   <= '0;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  if (idx_q == 3'd7) begin
                     state_q <= has_parity ? S_PARITY : S_STOP;
                     stop2_q <= 1'b0;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end
            end
            S_PARITY: begin
               if (bit_end) begin
                  state_q <= S_STOP;
                  stop2_q <= 1'b0;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  if (two_stop && !stop2_q) begin
                     stop2_q <= 1'b1;
                  end else if (load) begin
                     state_q <= S_START;
                     shift_q <= hold_q;
                     mode_q  <= uart_mode;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wr.uart_wr_ready = ready_q;
   assign uart_txd         = txd_q;
   assign tx_busy          = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: expected frames are queued on accept and a
// cycle-accurate line monitor compares every txd cycle against the model.
module tb_uart_tx;

   localparam int CLK_FREQ = 1600000;
   localparam int BAUD     = 100000;
   localparam int B        = CLK_FREQ / BAUD;   // 16 clocks per bit
   localparam int TO       = 60 * B;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] mode = 2'b00;
   logic       txd;
   logic       busy;

   uart_tx_if io ();

   uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr        (io.slave),
      .uart_mode (mode),
      .uart_txd  (txd),
      .tx_busy   (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int frames = 0;
   logic [9:0] sb[$];     // {mode, data} in send order
   int         starts[$]; // cycle of each observed start-bit fall

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Line monitor: on each start fall, pop the expected frame and check
   // the level of txd on every clock of the frame.
   logic prev_txd = 1'b1;
   logic mon_act  = 1'b0;
   int   mcnt;
   int   nb;
   logic lv[11];

   always @(negedge clk) begin
      if (rst) begin
         mon_act  = 1'b0;
         prev_txd = 1'b1;
      end else if (!mon_act) begin
         if (prev_txd && !txd) begin
            starts.push_back(cyc);
            chk("frame_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               logic [9:0] e;
               int ones;
               e = sb.pop_front();
               ones = 0;
               for (int i = 0; i < 8; i++) ones += int'(e[i]);
               lv[0] = 1'b0;
               for (int i = 0; i < 8; i++) lv[i+1] = e[i];
               lv[10] = 1'b1;
               case (e[9:8])
                  2'b00: begin lv[9] = 1'b1;            nb = 10; end
                  2'b01: begin lv[9] = ones[0];         nb = 11; end
                  2'b10: begin lv[9] = ~ones[0];        nb = 11; end
                  default: begin lv[9] = 1'b1;          nb = 11; end
               endcase
               mcnt    = 0;
               mon_act = 1'b1;
               chk("line_bit0", txd, lv[0]);
            end
         end
         prev_txd = txd;
      end else begin
         mcnt++;
         chk($sformatf("line_bit%0d_cyc%0d", mcnt / B, mcnt % B), txd, lv[mcnt / B]);
         if (mcnt == nb * B - 1) begin
            mon_act  = 1'b0;
            prev_txd = 1'b1;
            frames++;
         end
      end
   end

   function automatic int last_start();
      return (starts.size() == 0) ? -100000 : starts[starts.size()-1];
   endfunction

   // Must be entered on a negedge; returns on the negedge after the accept.
   task automatic send(input logic [7:0] d, input logic [1:0] m, input bit keep, output int acc);
      int n;
      n = 0;
      io.uart_wr_data  = d;
      io.uart_wr_valid = 1'b1;
      while (!io.uart_wr_ready && n < TO) begin
         @(negedge clk);
         n++;
      end
      chk("accept_in_time", n < TO, 1);
      @(posedge clk);
      sb.push_back({m, d});
      @(negedge clk);
      acc = cyc;
      chk("ready_low_when_held", io.uart_wr_ready, 1'b0);
      if (!keep) io.uart_wr_valid = 1'b0;
   endtask

   task automatic wait_idle(output int t);
      int n;
      n = 0;
      repeat (2) @(negedge clk);
      while (busy && n < TO) begin
         @(negedge clk);
         n++;
      end
      chk("idle_in_time", n < TO, 1);
      t = cyc;
   endtask

   initial begin
      int acc;
      int t;
      int bad;
      io.uart_wr_valid = 1'b0;
      io.uart_wr_data  = 8'h00;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_txd",   txd,              1'b1);
      chk("rst_ready", io.uart_wr_ready, 1'b0);
      chk("rst_busy",  busy,             1'b0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1 chk("ready_after_rst", io.uart_wr_ready, 1'b1);
      @(negedge clk);

      // 0x55 8N1: latency and busy length
      send(8'h55, 2'b00, 0, acc);
      wait_idle(t);
      chk("start_latency", last_start() - acc, 2);
      chk("busy_fall_8n1", t - last_start(), 10 * B);

      // 0xA3 even then odd parity
      mode = 2'b01;
      send(8'hA3, 2'b01, 0, acc);
      wait_idle(t);
      chk("busy_fall_8e1", t - last_start(), 11 * B);
      mode = 2'b10;
      send(8'hA3, 2'b10, 0, acc);
      wait_idle(t);
      chk("busy_fall_8o1", t - last_start(), 11 * B);

      // 0x00 with two stop bits
      mode = 2'b11;
      send(8'h00, 2'b11, 0, acc);
      wait_idle(t);
      chk("busy_fall_8n2", t - last_start(), 11 * B);

      // Back-to-back with valid held high
      mode = 2'b00;
      starts.delete();
      send(8'h00, 2'b00, 1, acc);
      send(8'hFF, 2'b00, 1, acc);
      send(8'h81, 2'b00, 0, acc);
      wait_idle(t);
      chk("b2b_frames", starts.size(), 3);
      if (starts.size() == 3) begin
         chk("b2b_gap01", starts[1] - starts[0], 10 * B);
         chk("b2b_gap12", starts[2] - starts[1], 10 * B);
      end

      // Mode change mid-frame only affects the next frame
      send(8'h0F, 2'b00, 0, acc);
      repeat (5 * B) @(negedge clk);
      mode = 2'b01;
      send(8'h3C, 2'b01, 0, acc);
      wait_idle(t);
      chk("busy_fall_after_toggle", t - last_start(), 11 * B);

      // Reset mid-data with a byte held
      mode = 2'b00;
      send(8'hC3, 2'b00, 0, acc);
      send(8'h99, 2'b00, 0, acc);
      repeat (3 * B) @(negedge clk);
      chk("held_before_abort", busy, 1'b1);
      @(posedge clk); #1 rst = 1'b1;
      sb.delete();
      @(posedge clk); #1;
      chk("abort_txd",   txd,              1'b1);
      chk("abort_ready", io.uart_wr_ready, 1'b0);
      chk("abort_busy",  busy,             1'b0);
      rst = 1'b0;
      @(posedge clk); #1 chk("abort_ready_back", io.uart_wr_ready, 1'b1);
      bad = 0;
      repeat (4 * B) begin
         @(negedge clk);
         if (txd !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("held_byte_dropped", bad, 0);
      send(8'h5A, 2'b00, 0, acc);
      wait_idle(t);
      chk("post_abort_latency", last_start() - acc, 2);

      chk("sb_drained", sb.size(), 0);
      chk("frames_seen", frames, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
